// File: rtl/clkcnt_freqmeter_pkg.sv
// clkcnt_freqmeter_pkg: shared FSM encoding, default constants and saturating shift
package clkcnt_freqmeter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GATE = 2'd1, LATCH = 2'd2, OUT = 2'd3} state_t;
  localparam int DEF_CNT_BIT = 3;
  localparam int DEF_GATE_CYCLES = 100000000;
  // v << sh clamped to w bits of all-ones when any set bit would be shifted out
  function automatic logic [63:0] sat_shl(input logic [63:0] v, input int sh, input int w);
    logic [127:0] s;
    logic [63:0] ones;
    ones = {64{1'b1}} >> (64 - w);
    s = {64'd0, v} << sh;
    return (s > {64'd0, ones}) ? ones : s[63:0];
  endfunction
endpackage

// File: rtl/clkcnt_edgecount.sv
// clkcnt_edgecount: synchronize one counter bit and count its edges, saturating
module clkcnt_edgecount #(
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              din,
  input  logic              clr,
  input  logic              en,
  output logic [CWIDTH-1:0] edges
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      s <= '0;
      edges <= '0;
    end else begin
      s <= {s[1:0], din};
      if (clr) edges <= '0;
      else if (en && (s[2] ^ s[1]) && !(&edges)) edges <= edges + 1'b1;
    end
endmodule

// File: rtl/clkcnt_freqmeter.sv
// clkcnt_freqmeter: gated edge counting of async counter bits, results drained per channel
module clkcnt_freqmeter
  import clkcnt_freqmeter_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int CNT_BIT     = DEF_CNT_BIT,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CWIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NCH*CWIDTH-1:0] cnt_in,
  input  logic                  mmcm_locked,
  input  logic                  run,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [1:0]            result_chan,
  output logic [CWIDTH-1:0]     result_cycles,
  output logic                  result_stuck,
  output logic                  result_unlocked
);
  state_t state, nxt;
  logic [31:0] gcnt;
  logic [1:0] lk;
  logic unl, unl_snap, last, last_k;
  logic [1:0] k;
  logic [CWIDTH-1:0] edges [NCH];
  logic [CWIDTH-1:0] cyc [NCH];
  logic [NCH-1:0] stk;
  assign last = gcnt == 32'(GATE_CYCLES - 1);
  assign last_k = k == 2'(NCH - 1);
  // the closing gate cycle is excluded so edges never race the snapshot
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clkcnt_edgecount #(.CWIDTH(CWIDTH)) u_ec (
      .clk(clk),
      .resetn(resetn),
      .din(cnt_in[i*CWIDTH+CNT_BIT]),
      .clr(state == IDLE),
      .en(state == GATE && !last),
      .edges(edges[i])
    );
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = run ? GATE : IDLE;
      GATE:  nxt = !run ? IDLE : last ? LATCH : GATE;
      LATCH: nxt = OUT;
      OUT:   nxt = (result_ready && last_k) ? IDLE : OUT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      gcnt <= '0;
      lk <= '0;
      unl <= 1'b0;
      unl_snap <= 1'b0;
      k <= '0;
      stk <= '0;
      for (int i = 0; i < NCH; i++) cyc[i] <= '0;
    end else begin
      state <= nxt;
      lk <= {lk[0], mmcm_locked};
      gcnt <= (state == GATE) ? gcnt + 1'b1 : '0;
      unl <= (state == IDLE) ? 1'b0 : (state == GATE && !lk[1]) ? 1'b1 : unl;
      if (state == LATCH) begin
        unl_snap <= unl;
        k <= '0;
        for (int i = 0; i < NCH; i++) begin
          cyc[i] <= CWIDTH'(sat_shl(64'(edges[i]), CNT_BIT, CWIDTH));
          stk[i] <= edges[i] == '0;
        end
      end else if (state == OUT && result_ready) k <= last_k ? 2'd0 : k + 2'd1;
    end
  assign busy = state == GATE;
  assign result_valid = state == OUT;
  assign result_chan = k;
  assign result_cycles = cyc[k];
  assign result_stuck = stk[k];
  assign result_unlocked = unl_snap;
endmodule

// File: tb/tb_clkcnt_freqmeter.sv
// tb_clkcnt_freqmeter: randomized frequency measurement bench with a rate-based reference model
module tb_clkcnt_freqmeter;
  timeunit 1ns;
  timeprecision 1ps;
  import clkcnt_freqmeter_pkg::*;
  localparam int G = 1000, N = 3, CW = 32;
  localparam real TCLK = 10.0, TOL = 16.0;

  logic clk = 1'b0, resetn = 1'b0, mmcm_locked = 1'b1, run = 1'b0, result_ready = 1'b1;
  logic busy, result_valid, result_stuck, result_unlocked;
  logic [1:0] result_chan;
  logic [CW-1:0] result_cycles;
  logic [N*CW-1:0] cnt_in;
  realtime per [N] = '{5.0, 10.0, 8.0};
  logic frz [N] = '{1'b0, 1'b0, 1'b0};

  int n_cmp = 0, n_err = 0, n_xfer = 0, cyc = 0, t_busy = -1, exp_k = 0;
  logic exp_unl = 1'b0, no_valid = 1'b0, hold_q = 1'b0, busy_q = 1'b0, valid_q = 1'b0;
  logic [1:0] p_chan;
  logic [CW-1:0] p_cyc;
  logic p_stk, p_unl;
  longint last_cyc [N];
  logic last_stk [N];

  clkcnt_freqmeter #(.NCH(N), .CNT_BIT(3), .GATE_CYCLES(G), .CWIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .cnt_in(cnt_in), .mmcm_locked(mmcm_locked), .run(run),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_chan(result_chan), .result_cycles(result_cycles),
    .result_stuck(result_stuck), .result_unlocked(result_unlocked)
  );

  always #5 clk = ~clk;

  // free-running measured-clock counters, random start value and phase
  for (genvar g = 0; g < N; g++) begin : gen_cnt
    logic [CW-1:0] cv;
    assign cnt_in[g*CW +: CW] = cv;
    initial begin
      cv = $urandom;
      #($urandom_range(1, 9999) * 1ps);
      forever begin
        #(per[g]);
        if (!frz[g]) cv = cv + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic ok, input longint act, input longint req);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // ideal measured cycles in one gate window: f_meas * G / f_clk
  function automatic real exp_cycles(input int ch);
    return frz[ch] ? 0.0 : G * TCLK / per[ch];
  endfunction

  function automatic real rabs(input real d);
    return d < 0.0 ? -d : d;
  endfunction

  always @(negedge clk) begin
    int ch;
    real e;
    cyc++;
    if (!resetn) begin
      exp_k = 0; hold_q = 1'b0; busy_q = 1'b0; valid_q = 1'b0; t_busy = -1;
    end else begin
      if (busy && !busy_q) t_busy = cyc;
      if (result_valid && !valid_q)
        chk("latency", t_busy >= 0 && cyc - t_busy == G + 1, cyc - t_busy, G + 1);
      if (no_valid) chk("no_valid_after_abort", !result_valid, result_valid, 0);
      if (result_valid) begin
        ch = result_chan < N ? int'(result_chan) : 0;
        e = exp_cycles(ch);
        chk("chan", result_chan == exp_k, result_chan, exp_k);
        chk("cycles", rabs(real'(result_cycles) - e) <= TOL, result_cycles, longint'(e));
        chk("stuck", result_stuck == frz[ch], result_stuck, frz[ch]);
        chk("unlocked", result_unlocked == exp_unl, result_unlocked, exp_unl);
        if (hold_q)
          chk("stable", {result_chan, result_cycles, result_stuck, result_unlocked} ==
              {p_chan, p_cyc, p_stk, p_unl}, result_cycles, p_cyc);
        last_cyc[ch] = result_cycles;
        last_stk[ch] = result_stuck;
        if (result_ready) begin
          n_xfer++;
          exp_k = exp_k == N - 1 ? 0 : exp_k + 1;
        end
      end
      hold_q = result_valid && !result_ready;
      p_chan = result_chan; p_cyc = result_cycles; p_stk = result_stuck; p_unl = result_unlocked;
      busy_q = busy;
      valid_q = result_valid;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy == 1'b0, busy, 0);
    chk({nm, "_valid"}, result_valid == 1'b0, result_valid, 0);
    chk({nm, "_chan"}, result_chan == 2'd0, result_chan, 0);
    chk({nm, "_cycles"}, result_cycles == '0, result_cycles, 0);
    chk({nm, "_stuck"}, result_stuck == 1'b0, result_stuck, 0);
    chk({nm, "_unlocked"}, result_unlocked == 1'b0, result_unlocked, 0);
  endtask

  task automatic wait_busy;
    for (int i = 0; i < 20 && !busy; i++) step;
    chk("busy_start", busy, busy, 1);
  endtask

  task automatic wait_valid;
    for (int i = 0; i < G + 20 && !result_valid; i++) step;
    chk("valid_arrives", result_valid, result_valid, 1);
  endtask

  task automatic wait_xfers(input int target, input logic rnd);
    for (int i = 0; i < 400 && n_xfer < target; i++) begin
      if (rnd) result_ready = 1'($urandom_range(0, 1));
      step;
    end
    result_ready = 1'b1;
    chk("drain", n_xfer >= target, n_xfer, target);
  endtask

  // mode 0 plain, 1 lock glitch mid-gate, 2 ready held low 20 cycles, 3 random ready
  task automatic window(input int mode);
    int x0;
    x0 = n_xfer;
    run = 1'b1;
    wait_busy;
    if (mode == 1) begin
      repeat (300) step;
      exp_unl = 1'b1;
      mmcm_locked = 1'b0;
      repeat (5) step;
      mmcm_locked = 1'b1;
    end
    if (mode == 2) result_ready = 1'b0;
    wait_valid;
    run = 1'b0;
    if (mode == 2) begin
      repeat (20) step;
      chk("hold_chan", result_valid && result_chan == 2'd0, result_chan, 0);
      result_ready = 1'b1;
    end
    wait_xfers(x0 + N, mode == 3);
    repeat (20) step;
    chk("xfer_count", n_xfer - x0 == N, n_xfer - x0, N);
    chk("idle_after_drain", !result_valid && !busy, result_valid, 0);
    exp_unl = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    resetn = 1'b1;
    repeat (4) step;
    chk("sat_shl_fit", sat_shl(64'h1FFF_FFFF, 3, 32) == 64'hFFFF_FFF8, 0, 0);
    chk("sat_shl_clip", sat_shl(64'h2000_0000, 3, 32) == 64'hFFFF_FFFF, 0, 0);

    window(0);
    chk("pin_c0", rabs(real'(last_cyc[0]) - 2000.0) <= TOL, last_cyc[0], 2000);
    chk("pin_c1", rabs(real'(last_cyc[1]) - 1000.0) <= TOL, last_cyc[1], 1000);
    chk("pin_c2", rabs(real'(last_cyc[2]) - 1250.0) <= TOL, last_cyc[2], 1250);

    frz[1] = 1'b1;
    repeat (10) step;
    window(0);
    chk("pin_stuck_cyc", last_cyc[1] == 0, last_cyc[1], 0);
    chk("pin_stuck_flag", last_stk[1] == 1'b1, last_stk[1], 1);
    chk("pin_other_cyc", rabs(real'(last_cyc[2]) - 1250.0) <= TOL, last_cyc[2], 1250);
    frz[1] = 1'b0;
    repeat (10) step;

    window(1);
    window(0);
    window(2);

    run = 1'b1;
    wait_busy;
    repeat (500) step;
    run = 1'b0;
    step;
    chk("abort_busy", !busy, busy, 0);
    no_valid = 1'b1;
    repeat (G + 20) step;
    no_valid = 1'b0;
    window(0);

    run = 1'b1;
    wait_busy;
    wait_valid;
    run = 1'b0;
    step;
    chk("pre_reset_chan", result_valid && result_chan == 2'd1, result_chan, 1);
    resetn = 1'b0;
    #1;
    chk_zero("midout_reset");
    repeat (2) step;
    resetn = 1'b1;
    repeat (4) step;
    window(0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        per[i] = $urandom_range(30, 200) / 10.0;
        frz[i] = $urandom_range(0, 7) == 0;
      end
      repeat (10) step;
      window(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
